// File: rtl/fp_normalize_sp_if.sv
// fp_normalize_sp_if
//   Handshake and data bundle for the single-precision normalizer.
//   master: producer side (drives the input beat and out_ready).
//   slave : the normalizer (drives in_ready and the output beat).
//   Signals:
//     in_valid/in_ready, in_sign, in_exp[EXP_W], in_mant[MANT_W], in_rm[3]
//     out_valid/out_ready, out_sign, out_rm[3], out_exp_frac[33],
//     out_guard_bits[3], out_overflow, out_tiny
interface fp_normalize_sp_if #(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [2:0]        in_rm;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [2:0]        out_rm;
  logic [32:0]       out_exp_frac;
  logic [2:0]        out_guard_bits;
  logic              out_overflow;
  logic              out_tiny;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    input  in_ready, out_valid, out_sign, out_rm, out_exp_frac,
           out_guard_bits, out_overflow, out_tiny
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_rm, out_ready,
    output in_ready, out_valid, out_sign, out_rm, out_exp_frac,
           out_guard_bits, out_overflow, out_tiny
  );
endinterface

// File: rtl/fp_normalize_sp.sv
// fp_normalize_sp
//   Two-stage pipelined single-precision normalizer ahead of the rounder.
//   Stage 1 counts leading zeros and forms the normalized exponent; stage 2
//   shifts the mantissa (left for normals, further right for denormals) and
//   registers the pre-round {2'b00, exp, frac} word plus guard/round/sticky.
//   Ports:
//     clk   - clock
//     rst_n - asynchronous active-low reset
//     bus   - fp_normalize_sp_if.slave (valid/ready in, valid/ready out)
module fp_normalize_sp #(
  parameter int MANT_W = 48,
  parameter int EXP_W  = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  fp_normalize_sp_if.slave    bus
);
  localparam int LZ_W = $clog2(MANT_W + 1);
  localparam int NE_W = 12;

  // Stage 1 registers
  logic                   s1_valid_reg;
  logic                   s1_sign_reg;
  logic [2:0]             s1_rm_reg;
  logic [MANT_W-1:0]      s1_mant_reg;
  logic [LZ_W-1:0]        s1_lz_reg;
  logic                   s1_zero_reg;
  logic signed [NE_W-1:0] s1_norm_exp_reg;

  // Stage 2 (output) registers
  logic        s2_valid_reg;
  logic        s2_sign_reg;
  logic [2:0]  s2_rm_reg;
  logic [32:0] s2_exp_frac_reg;
  logic [2:0]  s2_guard_reg;
  logic        s2_overflow_reg;
  logic        s2_tiny_reg;

  logic s1_move;
  logic in_ready;

  assign s1_move  = !s2_valid_reg || bus.out_ready;
  assign in_ready = !s1_valid_reg || s1_move;

  // Leading-zero count: the highest set bit wins, all-zero gives MANT_W.
  logic [LZ_W-1:0] lz_next;
  always_comb begin
    lz_next = LZ_W'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (bus.in_mant[i]) lz_next = LZ_W'(MANT_W - 1 - i);
    end
  end

  logic signed [NE_W-1:0] norm_exp_next;
  assign norm_exp_next = $signed({{(NE_W-EXP_W){bus.in_exp[EXP_W-1]}}, bus.in_exp})
                         + NE_W'(1) - NE_W'(lz_next);

  // Stage 2 datapath
  logic [MANT_W-1:0]      m_norm;
  logic signed [NE_W-1:0] sh_full;
  logic [4:0]             sh;
  logic [MANT_W-1:0]      m_den;
  logic                   den_lost;

  assign m_norm   = s1_mant_reg << s1_lz_reg;
  assign sh_full  = NE_W'(1) - s1_norm_exp_reg;
  assign sh       = sh_full[4:0];
  assign m_den    = m_norm >> sh;
  // Bits pushed off the bottom by the denormal shift fold into sticky.
  assign den_lost = |(m_norm & ~({MANT_W{1'b1}} << sh));

  logic [32:0] exp_frac_next;
  logic [2:0]  guard_next;
  logic        overflow_next;
  logic        tiny_next;

  always_comb begin
    exp_frac_next = '0;
    guard_next    = '0;
    overflow_next = 1'b0;
    tiny_next     = 1'b0;
    if (!s1_zero_reg) begin
      if (s1_norm_exp_reg >= NE_W'(255)) begin
        overflow_next = 1'b1;
        exp_frac_next = {2'b00, 8'hFF, 23'h0};
      end else if (s1_norm_exp_reg >= NE_W'(1)) begin
        exp_frac_next = {2'b00, s1_norm_exp_reg[7:0], m_norm[MANT_W-2 -: 23]};
        guard_next    = {m_norm[MANT_W-25], m_norm[MANT_W-26], |m_norm[MANT_W-27:0]};
      end else begin
        tiny_next = 1'b1;
        if (sh_full > NE_W'(26)) begin
          // Everything lands below the round bit: only sticky survives.
          guard_next = 3'b001;
        end else begin
          exp_frac_next = {2'b00, 8'h00, m_den[MANT_W-2 -: 23]};
          guard_next    = {m_den[MANT_W-25], m_den[MANT_W-26],
                           (|m_den[MANT_W-27:0]) | den_lost};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg    <= 1'b0;
      s1_sign_reg     <= 1'b0;
      s1_rm_reg       <= '0;
      s1_mant_reg     <= '0;
      s1_lz_reg       <= '0;
      s1_zero_reg     <= 1'b0;
      s1_norm_exp_reg <= '0;
      s2_valid_reg    <= 1'b0;
      s2_sign_reg     <= 1'b0;
      s2_rm_reg       <= '0;
      s2_exp_frac_reg <= '0;
      s2_guard_reg    <= '0;
      s2_overflow_reg <= 1'b0;
      s2_tiny_reg     <= 1'b0;
    end else begin
      if (in_ready) s1_valid_reg <= bus.in_valid;
      if (in_ready && bus.in_valid) begin
        s1_sign_reg     <= bus.in_sign;
        s1_rm_reg       <= bus.in_rm;
        s1_mant_reg     <= bus.in_mant;
        s1_lz_reg       <= lz_next;
        s1_zero_reg     <= (bus.in_mant == '0);
        s1_norm_exp_reg <= norm_exp_next;
      end
      if (s1_move) s2_valid_reg <= s1_valid_reg;
      if (s1_move && s1_valid_reg) begin
        s2_sign_reg     <= s1_sign_reg;
        s2_rm_reg       <= s1_rm_reg;
        s2_exp_frac_reg <= exp_frac_next;
        s2_guard_reg    <= guard_next;
        s2_overflow_reg <= overflow_next;
        s2_tiny_reg     <= tiny_next;
      end
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = s2_valid_reg;
  assign bus.out_sign       = s2_sign_reg;
  assign bus.out_rm         = s2_rm_reg;
  assign bus.out_exp_frac   = s2_exp_frac_reg;
  assign bus.out_guard_bits = s2_guard_reg;
  assign bus.out_overflow   = s2_overflow_reg;
  assign bus.out_tiny       = s2_tiny_reg;
endmodule
